key_priority_encoder: RTL and testbench

//  Encoder-side counterpart of the lab decoder blocks: turns N raw key/switch lines into a binary key code.

---
 rtl/key_priority_encoder_pkg.sv | 14 +
 rtl/key_priority_encoder_debounce.sv | 62 ++++++
 rtl/key_priority_encoder.sv | 120 ++++++++++++
 tb/tb_key_priority_encoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_priority_encoder_pkg.sv
// Shared definitions for the key priority encoder: FSM state encoding and
// the default debounce length used when a parent does not override it.
package key_priority_encoder_pkg;

    // Event presentation FSM: waiting for a pending press, or holding one on the outputs
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } encState_e;

    // Default number of consecutive identical samples needed to accept a level change
    localparam int KEY_DEB_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/key_priority_encoder_debounce.sv
// Per-key front end: two-flop synchroniser followed by a counting debouncer.
// The debounced level only changes after DEB_CYCLES consecutive samples that
// disagree with it; rise pulses combinationally in the cycle whose clock edge
// will move the debounced level from 0 to 1.
module key_debounce
    import key_priority_encoder_pkg::*;
#(
    parameter int DEB_CYCLES = KEY_DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             update;

    // Debounce decision: count disagreeing samples, accept the new level on the last one
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        update   = 1'b0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = s2_q;
                cnt_d    = '0;
                update   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser chain, debounced level and counter, all cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= din;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;
    assign rise = update & ~stable_q;

endmodule

// File: rtl/key_priority_encoder.sv
// Key priority encoder: debounces N key lines, queues each press as a pending
// bit and presents pending events one at a time, lowest index first, over a
// valid/ack handshake. ovf is a sticky flag for presses that merged into an
// event that was still pending.
module key_priority_encoder
    import key_priority_encoder_pkg::*;
#(
    parameter int N          = 8,
    parameter int W          = 3,
    parameter int DEB_CYCLES = KEY_DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key_in,
    output logic [W-1:0] code,
    output logic         valid,
    input  logic         ack,
    output logic [N-1:0] pending,
    output logic         ovf
);

    logic [N-1:0] riseVec;
    logic [N-1:0] takeMask;
    logic [N-1:0] lowestMask;
    logic [N-1:0] pending_q;
    logic [N-1:0] pending_d;
    logic         ovf_q;
    logic         ovf_d;
    logic [W-1:0] code_q;
    logic [W-1:0] code_d;
    logic         valid_q;
    logic         valid_d;
    encState_e    state_q;
    encState_e    state_d;

    // Index of the lowest set bit; the caller guarantees at least one bit is set
    function automatic logic [W-1:0] lowestIndex(input logic [N-1:0] vec);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
        return idx;
    endfunction

    for (genvar g = 0; g < N; g++) begin : gen_deb
        key_debounce #(
            .DEB_CYCLES(DEB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_deb (
            .clk (clk),
            .rst (rst),
            .din (key_in[g]),
            .dout(),
            .rise(riseVec[g])
        );
    end

    assign lowestMask = pending_q & (~pending_q + 1'b1);

    // FSM next state and output registers: take the lowest pending event in IDLE, hold it until ack
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        valid_d  = valid_q;
        takeMask = '0;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    takeMask = lowestMask;
                    code_d   = lowestIndex(pending_q);
                    valid_d  = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending queue update: a new press wins over the bit being taken, and only merges into older events raise ovf
    always_comb begin
        pending_d = (pending_q & ~takeMask) | riseVec;
        ovf_d     = ovf_q | (|(riseVec & pending_q & ~takeMask));
    end

    // State, output and queue registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_key_priority_encoder.sv
// Testbench for key_priority_encoder with N=8, W=3, DEB_CYCLES=4.
// Expected codes are queued as keys are pressed; a monitor pops one entry on
// every rising edge of valid and compares it with the presented code.
module tb_key_priority_encoder;

    localparam int N   = 8;
    localparam int W   = 3;
    localparam int DEB = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] key_in;
    logic [W-1:0] code;
    logic         valid;
    logic         ack;
    logic [N-1:0] pending;
    logic         ovf;

    int           compareCount;
    int           failCount;
    logic [W-1:0] expQ[$];
    logic         prevValid;
    logic         benchDone;

    key_priority_encoder #(
        .N         (N),
        .W         (W),
        .DEB_CYCLES(DEB),
        .CNT_W     (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key_in (key_in),
        .code   (code),
        .valid  (valid),
        .ack    (ack),
        .pending(pending),
        .ovf    (ovf)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard monitor: each new event on the outputs must match the oldest expected code
    initial begin
        prevValid = 1'b0;
        forever begin
            @(negedge clk);
            if (valid && !prevValid) begin
                compareCount++;
                if (expQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL event_code: actual=%0d required=no event", code);
                end else begin
                    logic [W-1:0] e;
                    e = expQ.pop_front();
                    if (code !== e) begin
                        failCount++;
                        $display("[TB] FAIL event_code: actual=%0d required=%0d", code, e);
                    end
                end
            end
            prevValid = valid;
        end
    end

    task automatic applyStimulus(input logic [N-1:0] keys, input logic ackVal);
        key_in = keys;
        ack    = ackVal;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        compareCount = 0;
        failCount    = 0;
        benchDone    = 1'b0;
        rst          = 1'b1;
        applyStimulus(8'h00, 1'b0);
        tick(3);
        rst = 1'b0;
        checkOutput("reset_valid",   32'(valid),   32'd0);
        checkOutput("reset_code",    32'(code),    32'd0);
        checkOutput("reset_pending", 32'(pending), 32'd0);
        checkOutput("reset_ovf",     32'(ovf),     32'd0);
        tick(2);

        $display("[TB] single press");
        expQ.push_back(3'd5);
        applyStimulus(8'h20, 1'b0);
        tick(1);
        tick(4);
        checkOutput("t1_pend_before", 32'(pending), 32'h00);
        tick(1);
        checkOutput("t1_pend_edge5",  32'(pending), 32'h20);
        checkOutput("t1_valid_edge5", 32'(valid),   32'd0);
        tick(1);
        checkOutput("t1_valid_edge6", 32'(valid),   32'd1);
        checkOutput("t1_code_edge6",  32'(code),    32'd5);
        checkOutput("t1_pend_edge6",  32'(pending), 32'h00);
        tick(3);
        checkOutput("t1_valid_hold",  32'(valid),   32'd1);
        checkOutput("t1_code_hold",   32'(code),    32'd5);
        applyStimulus(8'h20, 1'b1);
        tick(1);
        applyStimulus(8'h20, 1'b0);
        checkOutput("t1_valid_ack",   32'(valid),   32'd0);
        applyStimulus(8'h00, 1'b0);
        tick(10);

        $display("[TB] glitch");
        applyStimulus(8'h04, 1'b0);
        tick(3);
        applyStimulus(8'h00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checkOutput("t2_valid", 32'(valid),   32'd0);
            checkOutput("t2_pend",  32'(pending), 32'h00);
        end

        $display("[TB] simultaneous press");
        expQ.push_back(3'd0);
        expQ.push_back(3'd3);
        expQ.push_back(3'd7);
        applyStimulus(8'h89, 1'b1);
        tick(6);
        checkOutput("t3_pend_all", 32'(pending), 32'h89);
        tick(1);
        checkOutput("t3_first",    32'(code),    32'd0);
        checkOutput("t3_pend_rest", 32'(pending), 32'h88);
        tick(15);
        checkOutput("t3_ovf",      32'(ovf),     32'd0);
        checkOutput("t3_pend_end", 32'(pending), 32'h00);
        checkOutput("t3_drained",  32'(expQ.size()), 32'd0);
        applyStimulus(8'h00, 1'b0);
        tick(10);

        $display("[TB] overflow");
        expQ.push_back(3'd1);
        applyStimulus(8'h02, 1'b0);
        tick(8);
        checkOutput("t4_code1",    32'(code),    32'd1);
        applyStimulus(8'h42, 1'b0);
        tick(6);
        checkOutput("t4_pend6",    32'(pending), 32'h40);
        checkOutput("t4_ovf_pre",  32'(ovf),     32'd0);
        applyStimulus(8'h02, 1'b0);
        tick(5);
        applyStimulus(8'h42, 1'b0);
        tick(8);
        checkOutput("t4_pend_ovf", 32'(pending), 32'h40);
        checkOutput("t4_ovf",      32'(ovf),     32'd1);
        checkOutput("t4_hold1",    32'(code),    32'd1);
        expQ.push_back(3'd6);
        applyStimulus(8'h42, 1'b1);
        tick(1);
        applyStimulus(8'h42, 1'b0);
        tick(3);
        checkOutput("t4_code6",    32'(code),    32'd6);
        applyStimulus(8'h42, 1'b1);
        tick(1);
        applyStimulus(8'h00, 1'b0);
        tick(12);
        checkOutput("t4_pend_end", 32'(pending), 32'h00);
        checkOutput("t4_ovf_stick", 32'(ovf),    32'd1);
        checkOutput("t4_drained",  32'(expQ.size()), 32'd0);

        $display("[TB] reset mid-operation");
        expQ.push_back(3'd1);
        applyStimulus(8'h0E, 1'b0);
        tick(9);
        checkOutput("t5_valid_pre", 32'(valid),   32'd1);
        checkOutput("t5_pend_pre",  32'(pending), 32'h0C);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("t5_valid_rst", 32'(valid),   32'd0);
        checkOutput("t5_code_rst",  32'(code),    32'd0);
        checkOutput("t5_pend_rst",  32'(pending), 32'h00);
        checkOutput("t5_ovf_rst",   32'(ovf),     32'd0);
        expQ.push_back(3'd1);
        expQ.push_back(3'd2);
        expQ.push_back(3'd3);
        tick(5);
        checkOutput("t5_pend_early", 32'(pending), 32'h00);
        tick(1);
        checkOutput("t5_pend_again", 32'(pending), 32'h0E);
        checkOutput("t5_valid_gap",  32'(valid),   32'd0);
        tick(1);
        checkOutput("t5_valid_again", 32'(valid),  32'd1);
        checkOutput("t5_code_again",  32'(code),   32'd1);
        applyStimulus(8'h0E, 1'b1);
        tick(10);
        checkOutput("t5_drained",  32'(expQ.size()), 32'd0);

        $display("[TB] release");
        expQ.push_back(3'd4);
        applyStimulus(8'h10, 1'b1);
        tick(12);
        applyStimulus(8'h00, 1'b1);
        tick(15);
        checkOutput("t6_pend",     32'(pending), 32'h00);
        checkOutput("t6_valid",    32'(valid),   32'd0);
        checkOutput("t6_ovf",      32'(ovf),     32'd0);
        checkOutput("t6_drained",  32'(expQ.size()), 32'd0);
        applyStimulus(8'h00, 1'b0);
        tick(3);

        benchDone = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
